// File: rtl/snake_move_scheduler.sv
// Snake game scheduler: start/run/over FSM, frame-paced steps, turn FIFO.
// Optional pause state is built in when SNAKE_PAUSE_EN is defined.
module snake_move_scheduler #(
  parameter int BASE_FRAMES   = 8,
  parameter int MIN_FRAMES    = 2,
  parameter int SPEEDUP_SHIFT = 2
) (
  input  logic        clk_25MHz,
  input  logic        reset,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_pause,
  input  logic        frame_tick,
  input  logic [6:0]  score,
  input  logic        step_ack,
  input  logic        collision,
  output logic        step_req,
  output logic [1:0]  step_dir,
  output logic        clear_pulse,
  output logic [1:0]  phase,
  output logic [15:0] step_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_STEP = 3'd2,
    S_OVER = 3'd3
`ifdef SNAKE_PAUSE_EN
    , S_PAUSE = 3'd4
`endif
  } state_e;

  state_e state_q, state_d;

  logic [3:0] key_in, key_q, edge_w;
  logic       armed_q;
  logic       arrow, pause_ev, launch, ack;
  logic [1:0] cand, ref_dir;
  logic [6:0] sh;
  logic [7:0] period;

  logic [7:0]      fcnt_q, fcnt_d, period_q, period_d;
  logic [1:0]      cur_q, cur_d, cnt_q, cnt_d;
  logic [1:0][1:0] fifo_q, fifo_d;
  logic [15:0]     steps_q, steps_d;
  logic            clear_q, clear_d;

  assign key_in = {key_right, key_left, key_down, key_up};
  // Keys held across reset release must not count as presses.
  assign edge_w = key_in & ~key_q & {4{armed_q}};
  assign arrow  = |edge_w;

`ifdef SNAKE_PAUSE_EN
  logic kp_q, pend_q, pend_d;
  assign pause_ev = key_pause & ~kp_q & armed_q;
`else
  logic unused_pause;
  assign unused_pause = key_pause;
  assign pause_ev     = 1'b0;
`endif

  always_comb begin
    cand = 2'b11;
    if (edge_w[0])      cand = 2'b00;
    else if (edge_w[1]) cand = 2'b01;
    else if (edge_w[2]) cand = 2'b10;
  end

  assign sh = score >> SPEEDUP_SHIFT;
  always_comb begin
    if ({1'b0, sh} >= 8'(BASE_FRAMES - MIN_FRAMES))
      period = 8'(MIN_FRAMES);
    else
      period = 8'(BASE_FRAMES) - {1'b0, sh};
  end

  assign launch = (state_q == S_RUN) && frame_tick &&
                  (fcnt_q == period_q - 8'd1);
  assign ack    = (state_q == S_STEP) && step_ack;

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (arrow) state_d = S_RUN;
      S_RUN: begin
        if (launch)        state_d = S_STEP;
`ifdef SNAKE_PAUSE_EN
        else if (pause_ev) state_d = S_PAUSE;
`endif
      end
      S_STEP: begin
        if (ack) begin
          if (collision) state_d = S_OVER;
`ifdef SNAKE_PAUSE_EN
          else if (pend_q || pause_ev) state_d = S_PAUSE;
`endif
          else state_d = S_RUN;
        end
      end
      S_OVER: if (arrow) state_d = S_IDLE;
`ifdef SNAKE_PAUSE_EN
      S_PAUSE: if (pause_ev) state_d = S_RUN;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    step_req    = (state_q == S_STEP);
    step_dir    = cur_q;
    clear_pulse = clear_q;
    step_count  = steps_q;
    unique case (state_q)
      S_RUN, S_STEP: phase = 2'b01;
      S_OVER:        phase = 2'b11;
`ifdef SNAKE_PAUSE_EN
      S_PAUSE:       phase = 2'b10;
`endif
      default:       phase = 2'b00;
    endcase
  end

  always_comb begin
    fcnt_d   = fcnt_q;
    period_d = period_q;
    cur_d    = cur_q;
    fifo_d   = fifo_q;
    cnt_d    = cnt_q;
    steps_d  = steps_q;
    clear_d  = 1'b0;
    if (state_q == S_IDLE && arrow) begin
      clear_d  = 1'b1;
      fcnt_d   = '0;
      period_d = period;
      cur_d    = 2'b11;
      cnt_d    = '0;
      steps_d  = '0;
    end
    if (state_q == S_RUN && frame_tick) begin
      if (launch) begin
        fcnt_d   = '0;
        period_d = period;
        if (cnt_q != 2'd0) begin
          cur_d     = fifo_q[0];
          fifo_d[0] = fifo_q[1];
          cnt_d     = cnt_q - 2'd1;
        end
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
    if (ack && !collision && steps_q != 16'hFFFF)
      steps_d = steps_q + 16'd1;
    // Compare against the post-pop tail so a same-cycle pop frees a slot.
    if (cnt_d == 2'd0)      ref_dir = cur_d;
    else if (cnt_d == 2'd2) ref_dir = fifo_d[1];
    else                    ref_dir = fifo_d[0];
    if ((state_q == S_RUN || state_q == S_STEP) && arrow &&
        cnt_d != 2'd2 && cand != ref_dir &&
        (cand ^ ref_dir) != 2'b01) begin
      fifo_d[cnt_d[0]] = cand;
      cnt_d            = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      key_q    <= '0;
      armed_q  <= 1'b0;
      fcnt_q   <= '0;
      period_q <= 8'(BASE_FRAMES);
      cur_q    <= 2'b11;
      fifo_q   <= '0;
      cnt_q    <= '0;
      steps_q  <= '0;
      clear_q  <= 1'b0;
    end else begin
      key_q    <= key_in;
      armed_q  <= 1'b1;
      fcnt_q   <= fcnt_d;
      period_q <= period_d;
      cur_q    <= cur_d;
      fifo_q   <= fifo_d;
      cnt_q    <= cnt_d;
      steps_q  <= steps_d;
      clear_q  <= clear_d;
    end
  end

`ifdef SNAKE_PAUSE_EN
  always_comb begin
    pend_d = pend_q;
    if (state_q == S_STEP && pause_ev) pend_d = 1'b1;
    if (ack || state_q == S_IDLE)      pend_d = 1'b0;
  end

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      kp_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      kp_q   <= key_pause;
      pend_q <= pend_d;
    end
  end
`endif

endmodule

// File: tb/tb_snake_move_scheduler.sv
// Directed bench for snake_move_scheduler: period table plus
// hand-written FIFO, collision, restart and pause sequences.
module tb_snake_move_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  keys;
  logic        kp;
  logic        frame_tick;
  logic [6:0]  score;
  logic        step_ack;
  logic        collision;
  logic        step_req;
  logic [1:0]  step_dir;
  logic        clear_pulse;
  logic [1:0]  phase;
  logic [15:0] step_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  snake_move_scheduler dut (
    .clk_25MHz  (clk),
    .reset      (reset),
    .key_up     (keys[0]),
    .key_down   (keys[1]),
    .key_left   (keys[2]),
    .key_right  (keys[3]),
    .key_pause  (kp),
    .frame_tick (frame_tick),
    .score      (score),
    .step_ack   (step_ack),
    .collision  (collision),
    .step_req   (step_req),
    .step_dir   (step_dir),
    .clear_pulse(clear_pulse),
    .phase      (phase),
    .step_count (step_count)
  );

  typedef struct {
    logic [6:0] sc;
    int         per;
  } pvec_t;

  pvec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    keys       = '0;
    kp         = 1'b0;
    frame_tick = 1'b0;
    step_ack   = 1'b0;
    collision  = 1'b0;
    reset      = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic press(input logic [3:0] k);
    keys = k;
    cyc();
    keys = '0;
    cyc();
  endtask

  task automatic ftick(output logic r);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    r = step_req;
  endtask

  task automatic ticks_to_req(output int n);
    logic r;
    n = 0;
    r = 1'b0;
    for (int i = 0; i < 40 && !r; i++) begin
      ftick(r);
      n++;
    end
    if (!r) n = -1;
  endtask

  task automatic do_ack(input logic coll);
    step_ack  = 1'b1;
    collision = coll;
    cyc();
    step_ack  = 1'b0;
    collision = 1'b0;
  endtask

  initial begin
    int   n;
    int   hits;
    logic r;

    tbl[0] = '{7'd0,  8};
    tbl[1] = '{7'd3,  8};
    tbl[2] = '{7'd4,  7};
    tbl[3] = '{7'd12, 5};
    tbl[4] = '{7'd20, 3};
    tbl[5] = '{7'd23, 3};
    tbl[6] = '{7'd24, 2};
    tbl[7] = '{7'd99, 2};

    score = 7'd0;
    keys  = '0;
    kp    = 1'b0;
    frame_tick = 1'b0;
    step_ack   = 1'b0;
    collision  = 1'b0;
    reset = 1'b1;
    #2;
    check("rst_step_req", int'(step_req), 0);
    check("rst_step_dir", int'(step_dir), 3);
    check("rst_clear", int'(clear_pulse), 0);
    check("rst_phase", int'(phase), 0);
    check("rst_count", int'(step_count), 0);

    // Key held through reset release is not a start event
    keys = 4'b1000;
    cyc();
    reset = 1'b0;
    cyc();
    cyc();
    check("held_key_no_start", int'(phase), 0);
    keys = '0;
    cyc();

    keys = 4'b1000;
    cyc();
    check("start_clear_hi", int'(clear_pulse), 1);
    check("start_phase", int'(phase), 1);
    keys = '0;
    cyc();
    check("start_clear_lo", int'(clear_pulse), 0);
    ticks_to_req(n);
    check("first_step_ticks", n, 8);
    check("first_step_dir", int'(step_dir), 3);
    do_ack(1'b0);
    check("ack_drops_req", int'(step_req), 0);
    check("count_after_ack", int'(step_count), 1);

    // Stray ack outside a step is ignored
    do_ack(1'b1);
    check("stray_ack_phase", int'(phase), 1);
    check("stray_ack_count", int'(step_count), 1);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      score = tbl[i].sc;
      press(4'b1000);
      ticks_to_req(n);
      check($sformatf("period_s%0d_a", tbl[i].sc), n, tbl[i].per);
      do_ack(1'b0);
      ticks_to_req(n);
      check($sformatf("period_s%0d_b", tbl[i].sc), n, tbl[i].per);
      do_ack(1'b0);
    end

    // FIFO: up, left queued; down dropped as full
    do_reset();
    score = 7'd0;
    press(4'b1000);
    press(4'b0001);
    press(4'b0100);
    press(4'b0010);
    ticks_to_req(n);
    check("fifo_step1_ticks", n, 8);
    check("fifo_step1_dir", int'(step_dir), 0);
    do_ack(1'b0);
    ticks_to_req(n);
    check("fifo_step2_dir", int'(step_dir), 2);
    do_ack(1'b0);
    ticks_to_req(n);
    check("fifo_step3_dir", int'(step_dir), 2);
    do_ack(1'b0);

    // Reversal dropped; same-cycle up+left keeps only up
    do_reset();
    press(4'b1000);
    press(4'b0100);
    ticks_to_req(n);
    check("reversal_dir", int'(step_dir), 3);
    do_ack(1'b0);
    press(4'b0101);
    ticks_to_req(n);
    check("prio_dir", int'(step_dir), 0);
    do_ack(1'b0);
    press(4'b0001);
    ticks_to_req(n);
    check("dup_dir", int'(step_dir), 0);
    check("count_before_coll", int'(step_count), 2);

    // Collision ends the game
    do_ack(1'b1);
    check("coll_phase", int'(phase), 3);
    check("coll_req", int'(step_req), 0);
    check("coll_count", int'(step_count), 2);
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      ftick(r);
      if (r) hits++;
    end
    check("over_no_req", hits, 0);
    keys = 4'b1000;
    cyc();
    check("over_to_idle", int'(phase), 0);
    cyc();
    cyc();
    check("held_no_restart", int'(phase), 0);
    check("held_no_clear", int'(clear_pulse), 0);
    keys = '0;
    cyc();
    keys = 4'b0010;
    cyc();
    check("restart_phase", int'(phase), 1);
    check("restart_clear", int'(clear_pulse), 1);
    check("restart_count", int'(step_count), 0);
    keys = '0;
    cyc();
    ticks_to_req(n);
    check("restart_dir", int'(step_dir), 3);

    // Async reset abandons an outstanding request
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_req", int'(step_req), 0);
    check("async_rst_phase", int'(phase), 0);
    cyc();
    reset = 1'b0;
    cyc();

    do_reset();
    press(4'b1000);
    for (int i = 0; i < 3; i++) ftick(r);
    kp = 1'b1;
    cyc();
    kp = 1'b0;
    cyc();
`ifdef SNAKE_PAUSE_EN
    check("pause_phase", int'(phase), 2);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      ftick(r);
      if (r) hits++;
    end
    check("pause_no_req", hits, 0);
    kp = 1'b1;
    cyc();
    kp = 1'b0;
    cyc();
    check("resume_phase", int'(phase), 1);
    ticks_to_req(n);
    check("resume_ticks", n, 5);
`else
    check("pause_ignored", int'(phase), 1);
    ticks_to_req(n);
    check("nopause_ticks", n, 5);
`endif
    do_ack(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/snake_move_scheduler.md
# snake_move_scheduler

Sequences the snake game datapath: owns the start/run/over state machine, paces grid steps from the video frame tick with score-dependent speed, and queues arrow-key turns. Sits between the key inputs and the snake movement/collision datapath. It issues one step request per move period, waits for the datapath's acknowledge and collision verdict, and pulses a clear to the datapath on restart.

## Interface
- BASE_FRAMES, 8: frames per step at score 0
- MIN_FRAMES, 2: fastest allowed frames per step
- SPEEDUP_SHIFT, 2: period drops by 1 frame per 2^SPEEDUP_SHIFT points
- clk_25MHz  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_up, key_down, key_left, key_right  in  1 each  synchronous level keys
- key_pause  in  1  synchronous level key (used only with SNAKE_PAUSE_EN)
- frame_tick  in  1  one-cycle pulse per video frame
- score  in  7  current score, 0..99
- step_ack  in  1  datapath finished the requested step
- collision  in  1  qualified by step_ack: step hit wall or body
- step_req  out  1  step request, held until acknowledged
- step_dir  out  2  direction for this step: 00 up, 01 down, 10 left, 11 right
- clear_pulse  out  1  one-cycle datapath re-initialise
- phase  out  2  00 idle, 01 playing, 10 paused, 11 over
- step_count  out  16  acknowledged steps since start, saturating at 0xFFFF

## Operation
- Reset values: step_req=0, step_dir=11, clear_pulse=0, phase=00, step_count=0, FIFO empty, frame counter 0, FSM IDLE.
- Key events use the rising edge of each registered key. An edge present at reset release is not an event.
- Same-cycle arrow edges resolve by priority up > down > left > right. Only one event is taken per cycle.
- Direction FIFO holds 2 entries. A candidate is compared with the FIFO tail, or with cur_dir when the FIFO is empty.
  - A reversal (up/down or left/right pair) is dropped.
  - A duplicate is dropped.
  - A candidate arriving when the FIFO is full is dropped.
- FSM states:
  - IDLE: any arrow edge triggers the start sequence. clear_pulse=1 for one cycle, FIFO flushed, cur_dir=11, frame counter=0, step_count=0, next state RUN. The starting key is not enqueued.
  - RUN: frame_tick increments the frame counter.
    - A tick with counter == period-1 resets the counter to 0.
    - On that tick, pop the FIFO head into cur_dir (if non-empty), drive step_dir=new cur_dir, set step_req=1, and go to STEP.
  - STEP: step_req and step_dir are held. frame_tick is ignored (not counted). Arrow edges still enqueue.
    - step_ack with collision=0: step_req=0, step_count+1 (saturating), return to RUN.
    - step_ack with collision=1: step_req=0, step_count unchanged, go to OVER.
  - OVER: phase=11. Any arrow edge returns to IDLE, then one cycle later runs the IDLE start sequence only on a fresh edge. Each restart needs two distinct key presses.
- period = BASE_FRAMES - (score >> SPEEDUP_SHIFT), clamped to MIN_FRAMES when (score >> SPEEDUP_SHIFT) >= BASE_FRAMES - MIN_FRAMES. The subtraction must never underflow. period is sampled at each step launch.
- phase is 01 in both RUN and STEP.

## Timing
- step_req rises on the clock edge after the qualifying frame_tick is sampled.
- step_ack is honoured only while step_req=1. An ack with step_req=0 is ignored.
- An ack may arrive in the first cycle step_req is high. step_req falls on the edge that samples the ack.
- The earliest next step_req is period frame ticks after the return to RUN.
- clear_pulse is asserted on the edge after the starting key edge, coincident with the phase 00 to 01 transition.
- An asynchronous reset mid-STEP drops step_req immediately. The datapath must tolerate an abandoned request.

## Configuration
- SNAKE_PAUSE_EN defined: a key_pause edge in RUN enters PAUSE (phase=10).
  - PAUSE freezes the frame counter and ignores arrow edges. A further key_pause edge returns to RUN with the counter preserved.
  - A key_pause edge during STEP is latched and taken after a collision-free ack. It is discarded on collision.
  - key_pause is ignored in IDLE and OVER.
- SNAKE_PAUSE_EN undefined: key_pause is ignored, the PAUSE state does not exist, and phase never reads 10.

## Test plan
- Reset, then key_right edge: clear_pulse high exactly 1 cycle, phase 00 to 01. With score=0 and 8 frame_ticks, step_req rises after the 8th tick with step_dir=11.
- Score=20: period=3 (8-5=3). Score=99: period clamps to 2. Check tick counts between step_req rises.
- Moving right, press up, left, down in separate cycles within one period: FIFO holds up, left; down is dropped as full. Next two steps carry 00 then 10.
- Moving right, press left: edge dropped, next step_dir stays 11. Same-cycle up+left edges enqueue up only.
- step_ack with collision=1: phase becomes 11, step_count unchanged, no further step_req on later frame_ticks. A key edge returns to IDLE.
- With SNAKE_PAUSE_EN: pause after 3 of 8 frames, apply 20 frame_ticks, resume. step_req arrives after exactly 5 more ticks.
